// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bru_pkg
// Description : Shared types for the branch resolve unit and its update port.
// Revision    : 1.0 - initial release
// ============================================================================
package bru_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    // Training record returned to the fetch predictor one cycle after resolve.
    typedef struct packed {
        addr_t pc;
        logic  branch;
        logic  taken;
    } bp_update_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Hazard/datapath-side bundle of the branch resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    import bru_pkg::*;

    logic             BPF;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             BranchE;
    logic             ZeroE;
    addr_t            PCE;
    addr_t            PCTargetE;
    addr_t            PCPlus4E;
    logic             MispredictE;
    addr_t            RedirectPC;
    logic             FlushReqD;
    logic             FlushReqE;
    addr_t            PCB;
    logic             BranchB;
    logic             ZeroB;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] MispredCnt;

    // Driver side: fetch predictor, hazard unit and execute datapath.
    modport master (
        output BPF, StallF, StallD, FlushD, FlushE,
        output BranchE, ZeroE, PCE, PCTargetE, PCPlus4E,
        input  MispredictE, RedirectPC, FlushReqD, FlushReqE,
        input  PCB, BranchB, ZeroB, BranchCnt, MispredCnt
    );

    modport slave (
        input  BPF, StallF, StallD, FlushD, FlushE,
        input  BranchE, ZeroE, PCE, PCTargetE, PCPlus4E,
        output MispredictE, RedirectPC, FlushReqD, FlushReqE,
        output PCB, BranchB, ZeroB, BranchCnt, MispredCnt
    );

endinterface
`default_nettype wire

// File: rtl/sat_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_perf_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_MAX = '1;
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Carries the fetch prediction to E, detects mispredicts, drives
//               redirect/flush requests and the registered predictor update.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus
);

    logic       r_bp_d;
    logic       r_bp_e;
    bp_update_t r_upd;

    logic       w_taken_e;
    logic       w_mispredict_e;
    logic       w_unused_stall_f;

    // The D-stage hold already covers a fetch stall, so StallF is not needed here.
    assign w_unused_stall_f = bus.StallF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bp_d <= 1'b0;
            r_bp_e <= 1'b0;
            r_upd  <= '0;
        end else begin
            // Flush beats stall: a squashed slot must not keep a stale prediction.
            if (bus.FlushD) begin
                r_bp_d <= 1'b0;
            end else if (!bus.StallD) begin
                r_bp_d <= bus.BPF;
            end

            r_bp_e <= bus.FlushE ? 1'b0 : r_bp_d;

            r_upd.pc     <= bus.PCE;
            r_upd.branch <= bus.BranchE;
            r_upd.taken  <= w_taken_e;
        end
    end

    assign w_taken_e      = bus.BranchE & bus.ZeroE;
    assign w_mispredict_e = bus.BranchE & (r_bp_e ^ w_taken_e);

    assign bus.MispredictE = w_mispredict_e;
    assign bus.RedirectPC  = w_mispredict_e ? (w_taken_e ? bus.PCTargetE : bus.PCPlus4E)
                                            : '0;
    assign bus.FlushReqD   = w_mispredict_e;
    assign bus.FlushReqE   = w_mispredict_e;

    assign bus.PCB     = r_upd.pc;
    assign bus.BranchB = r_upd.branch;
    assign bus.ZeroB   = r_upd.taken;

    sat_perf_counter #(
        .W     (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.BranchE),
        .count (bus.BranchCnt)
    );

    sat_perf_counter #(
        .W     (CNT_W)
    ) u_mispred_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_mispredict_e),
        .count (bus.MispredCnt)
    );

endmodule
`default_nettype wire
